// File: rtl/cv32e40s_rvfi_obi_instr_tracker.sv
`default_nettype none
// cv32e40s_rvfi_obi_instr_tracker: pairs granted instruction-OBI requests with their
// responses in order and hands completed RVFI records to the retire logic.

package cv32e40s_rvfi_obi_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  memtype;
    logic [2:0]  prot;
    logic        dbg;
  } obi_inst_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  mpu_status;
  } obi_inst_resp_t;

  typedef struct packed {
    obi_inst_req_t  req_payload;
    obi_inst_resp_t resp_payload;
  } rvfi_obi_instr_t;

endpackage

module cv32e40s_rvfi_obi_instr_tracker
  import cv32e40s_rvfi_obi_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         obi_req_i,
  input  logic                         obi_gnt_i,
  input  obi_inst_req_t                obi_req_payload_i,
  input  logic                         obi_rvalid_i,
  input  obi_inst_resp_t               obi_resp_payload_i,
  output logic                         rec_valid_o,
  input  logic                         rec_ready_i,
  output rvfi_obi_instr_t              rec_o,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding_o,
  output logic                         err_protocol_o,
  output logic                         err_overflow_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  obi_inst_req_t   pend_mem [DEPTH];
  rvfi_obi_instr_t rec_mem  [DEPTH];

  logic [PW-1:0] pend_wptr_q, pend_wptr_d;
  logic [PW-1:0] pend_rptr_q, pend_rptr_d;
  logic [CW-1:0] pend_cnt_q,  pend_cnt_d;
  logic [PW-1:0] rec_wptr_q,  rec_wptr_d;
  logic [PW-1:0] rec_rptr_q,  rec_rptr_d;
  logic [CW-1:0] rec_cnt_q,   rec_cnt_d;
  logic          err_protocol_q, err_protocol_d;
  logic          err_overflow_q, err_overflow_d;

  logic pend_empty, pend_full, rec_empty, rec_full;
  logic grant, pend_pop, pend_push, rec_pop, rec_push;
  rvfi_obi_instr_t new_rec;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign pend_empty = (pend_cnt_q == '0);
  assign pend_full  = (pend_cnt_q == CW'(DEPTH));
  assign rec_empty  = (rec_cnt_q == '0);
  assign rec_full   = (rec_cnt_q == CW'(DEPTH));

  // Pops are resolved first so a full queue can still take a same-cycle push.
  assign grant     = obi_req_i && obi_gnt_i;
  assign pend_pop  = obi_rvalid_i && !pend_empty;
  assign pend_push = grant && (!pend_full || pend_pop);
  assign rec_pop   = !rec_empty && rec_ready_i;
  assign rec_push  = pend_pop && (!rec_full || rec_pop);

  assign new_rec.req_payload  = pend_mem[pend_rptr_q];
  assign new_rec.resp_payload = obi_resp_payload_i;

  always_comb begin
    pend_wptr_d    = pend_wptr_q;
    pend_rptr_d    = pend_rptr_q;
    pend_cnt_d     = pend_cnt_q;
    rec_wptr_d     = rec_wptr_q;
    rec_rptr_d     = rec_rptr_q;
    rec_cnt_d      = rec_cnt_q;
    err_protocol_d = err_protocol_q;
    err_overflow_d = err_overflow_q;

    if (pend_pop) begin
      pend_rptr_d = ptr_inc(pend_rptr_q);
    end
    if (pend_push) begin
      pend_wptr_d = ptr_inc(pend_wptr_q);
    end
    case ({pend_push, pend_pop})
      2'b10:   pend_cnt_d = pend_cnt_q + CW'(1);
      2'b01:   pend_cnt_d = pend_cnt_q - CW'(1);
      default: pend_cnt_d = pend_cnt_q;
    endcase

    if (rec_pop) begin
      rec_rptr_d = ptr_inc(rec_rptr_q);
    end
    if (rec_push) begin
      rec_wptr_d = ptr_inc(rec_wptr_q);
    end
    case ({rec_push, rec_pop})
      2'b10:   rec_cnt_d = rec_cnt_q + CW'(1);
      2'b01:   rec_cnt_d = rec_cnt_q - CW'(1);
      default: rec_cnt_d = rec_cnt_q;
    endcase

    if ((obi_rvalid_i && pend_empty) || (grant && pend_full && !obi_rvalid_i)) begin
      err_protocol_d = 1'b1;
    end
    if (pend_pop && rec_full && !rec_pop) begin
      err_overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_wptr_q    <= '0;
      pend_rptr_q    <= '0;
      pend_cnt_q     <= '0;
      rec_wptr_q     <= '0;
      rec_rptr_q     <= '0;
      rec_cnt_q      <= '0;
      err_protocol_q <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      pend_wptr_q    <= pend_wptr_d;
      pend_rptr_q    <= pend_rptr_d;
      pend_cnt_q     <= pend_cnt_d;
      rec_wptr_q     <= rec_wptr_d;
      rec_rptr_q     <= rec_rptr_d;
      rec_cnt_q      <= rec_cnt_d;
      err_protocol_q <= err_protocol_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  // Payload storage is deliberately left unreset; validity comes from the counters.
  always_ff @(posedge clk) begin
    if (pend_push) begin
      pend_mem[pend_wptr_q] <= obi_req_payload_i;
    end
    if (rec_push) begin
      rec_mem[rec_wptr_q] <= new_rec;
    end
  end

  assign rec_valid_o    = !rec_empty;
  assign rec_o          = rec_empty ? '0 : rec_mem[rec_rptr_q];
  assign outstanding_o  = pend_cnt_q;
  assign err_protocol_o = err_protocol_q;
  assign err_overflow_o = err_overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_cv32e40s_rvfi_obi_instr_tracker.sv
`default_nettype none
// Directed bench for cv32e40s_rvfi_obi_instr_tracker with a queue-based reference model.

module tb_cv32e40s_rvfi_obi_instr_tracker;
  import cv32e40s_rvfi_obi_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic            clk;
  logic            rst_n;
  logic            req, gnt, rvalid, ready;
  obi_inst_req_t   req_pl;
  obi_inst_resp_t  resp_pl;
  logic            rec_valid;
  rvfi_obi_instr_t rec;
  logic [1:0]      outstanding;
  logic            err_p, err_o;

  int n_cmp = 0;
  int n_bad = 0;

  cv32e40s_rvfi_obi_instr_tracker #(.DEPTH(DEPTH)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .obi_req_i          (req),
    .obi_gnt_i          (gnt),
    .obi_req_payload_i  (req_pl),
    .obi_rvalid_i       (rvalid),
    .obi_resp_payload_i (resp_pl),
    .rec_valid_o        (rec_valid),
    .rec_ready_i        (ready),
    .rec_o              (rec),
    .outstanding_o      (outstanding),
    .err_protocol_o     (err_p),
    .err_overflow_o     (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obi_inst_req_t mk_req(input logic [31:0] a);
    obi_inst_req_t r;
    r.addr = a; r.memtype = 2'b01; r.prot = 3'b110; r.dbg = a[2];
    return r;
  endfunction

  function automatic obi_inst_resp_t mk_resp(input logic [31:0] d);
    obi_inst_resp_t r;
    r.rdata = d; r.err = d[0]; r.mpu_status = d[2:1];
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain queues following the pop-before-push rules.
  obi_inst_req_t   m_pend[$];
  rvfi_obi_instr_t m_rec[$];
  bit              m_errp, m_erro;

  always @(posedge clk or negedge rst_n) begin : model
    rvfi_obi_instr_t nr;
    bit              done;
    if (!rst_n) begin
      m_pend.delete(); m_rec.delete(); m_errp = 0; m_erro = 0;
    end else begin
      done = 0;
      if (m_rec.size() > 0 && ready) void'(m_rec.pop_front());
      if (rvalid) begin
        if (m_pend.size() == 0) m_errp = 1;
        else begin
          nr.req_payload  = m_pend.pop_front();
          nr.resp_payload = resp_pl;
          done = 1;
        end
      end
      if (req && gnt) begin
        if (m_pend.size() < DEPTH) m_pend.push_back(req_pl);
        else m_errp = 1;
      end
      if (done) begin
        if (m_rec.size() < DEPTH) m_rec.push_back(nr);
        else m_erro = 1;
      end
    end
  end

  always @(negedge clk) begin : compare
    rvfi_obi_instr_t exp_rec;
    if (rst_n === 1'b1) begin
      exp_rec = (m_rec.size() > 0) ? m_rec[0] : '0;
      chk("m_outstanding", 128'(outstanding), 128'(m_pend.size()));
      chk("m_rec_valid",   128'(rec_valid),   128'(m_rec.size() > 0));
      chk("m_rec",         128'(rec),         128'(exp_rec));
      chk("m_err_protocol", 128'(err_p),      128'(m_errp));
      chk("m_err_overflow", 128'(err_o),      128'(m_erro));
    end
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit g, input logic [31:0] a, input bit rv, input logic [31:0] d);
    req = g; gnt = g; req_pl = mk_req(a);
    rvalid = rv; resp_pl = mk_resp(d);
    tick();
    req = 0; gnt = 0; rvalid = 0;
  endtask

  task automatic do_reset;
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic chk_rec(input string name, input logic [31:0] a, input logic [31:0] d);
    chk({name, "_valid"}, 128'(rec_valid), 128'(1));
    chk({name, "_addr"},  128'(rec.req_payload.addr),  128'(a));
    chk({name, "_rdata"}, 128'(rec.resp_payload.rdata), 128'(d));
  endtask

  initial begin
    rst_n = 0; req = 0; gnt = 0; rvalid = 0; ready = 1;
    req_pl = '0; resp_pl = '0;
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    chk("rst_outstanding", 128'(outstanding), 128'(0));
    chk("rst_rec_valid",   128'(rec_valid),   128'(0));
    chk("rst_rec",         128'(rec),         128'(0));
    chk("rst_errs",        128'({err_p, err_o}), 128'(0));

    // Single transaction
    drive(1, 32'h80, 0, 0);
    chk("t1_out_c2", 128'(outstanding), 128'(1));
    drive(0, 0, 0, 0);
    chk("t1_out_c3", 128'(outstanding), 128'(1));
    drive(0, 0, 1, 32'h13);
    chk("t1_out_c4", 128'(outstanding), 128'(0));
    chk_rec("t1_rec", 32'h80, 32'h13);
    drive(0, 0, 0, 0);
    chk("t1_valid_c5", 128'(rec_valid), 128'(0));

    // Pipelined pair with backpressure
    ready = 0;
    drive(1, 32'h100, 0, 0);
    drive(1, 32'h104, 0, 0);
    drive(0, 0, 1, 32'hA);
    drive(0, 0, 1, 32'hB);
    chk_rec("t2_c5", 32'h100, 32'hA);
    drive(0, 0, 0, 0);
    chk_rec("t2_c6", 32'h100, 32'hA);
    drive(0, 0, 0, 0);
    chk_rec("t2_c7", 32'h100, 32'hA);
    ready = 1;
    drive(0, 0, 0, 0);
    chk_rec("t2_c8", 32'h104, 32'hB);
    drive(0, 0, 0, 0);
    chk("t2_empty", 128'(rec_valid), 128'(0));
    chk("t2_errs",  128'({err_p, err_o}), 128'(0));

    // Full pending queue: grant and rvalid together
    drive(1, 32'h200, 0, 0);
    drive(1, 32'h204, 0, 0);
    chk("t3_full", 128'(outstanding), 128'(2));
    drive(1, 32'h208, 1, 32'h20);
    chk("t3_out_stays", 128'(outstanding), 128'(2));
    chk("t3_no_err",    128'(err_p), 128'(0));
    chk_rec("t3_r0", 32'h200, 32'h20);
    drive(0, 0, 1, 32'h21);
    chk_rec("t3_r1", 32'h204, 32'h21);
    drive(0, 0, 1, 32'h22);
    chk_rec("t3_r2", 32'h208, 32'h22);
    chk("t3_out0", 128'(outstanding), 128'(0));
    drive(0, 0, 0, 0);

    // Protocol error: rvalid with nothing outstanding
    drive(0, 0, 1, 32'h99);
    chk("t4_errp", 128'(err_p), 128'(1));
    chk("t4_novalid", 128'(rec_valid), 128'(0));
    drive(1, 32'h300, 0, 0);
    drive(0, 0, 1, 32'h30);
    chk_rec("t4_pair", 32'h300, 32'h30);
    chk("t4_sticky", 128'(err_p), 128'(1));
    drive(0, 0, 0, 0);

    // Overflow
    do_reset();
    chk("t5_errp_clr", 128'(err_p), 128'(0));
    ready = 0;
    drive(1, 32'h400, 0, 0);
    drive(1, 32'h404, 0, 0);
    drive(0, 0, 1, 32'h40);
    drive(0, 0, 1, 32'h41);
    chk("t5_no_ovf_yet", 128'(err_o), 128'(0));
    drive(1, 32'h408, 0, 0);
    drive(0, 0, 1, 32'h42);
    chk("t5_ovf", 128'(err_o), 128'(1));
    chk("t5_out0", 128'(outstanding), 128'(0));
    chk_rec("t5_head", 32'h400, 32'h40);
    ready = 1;
    drive(0, 0, 0, 0);
    chk_rec("t5_second", 32'h404, 32'h41);
    drive(0, 0, 0, 0);
    chk("t5_empty", 128'(rec_valid), 128'(0));

    // Reset mid-flight
    do_reset();
    ready = 0;
    drive(1, 32'h500, 0, 0);
    drive(0, 0, 1, 32'h50);
    drive(1, 32'h504, 0, 0);
    drive(1, 32'h508, 0, 0);
    chk("t6_out2",   128'(outstanding), 128'(2));
    chk("t6_valid1", 128'(rec_valid),   128'(1));
    #2 rst_n = 0;
    #1;
    chk("t6_rst_out",   128'(outstanding), 128'(0));
    chk("t6_rst_valid", 128'(rec_valid),   128'(0));
    chk("t6_rst_rec",   128'(rec),         128'(0));
    chk("t6_rst_errs",  128'({err_p, err_o}), 128'(0));
    @(negedge clk);
    rst_n = 1;
    ready = 1;
    drive(0, 0, 1, 32'h55);
    chk("t6_stray_errp", 128'(err_p), 128'(1));
    chk("t6_stray_norec", 128'(rec_valid), 128'(0));
    drive(0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
